// File: rtl/step_pulse_pkg.sv
// Shared definitions for the step/direction pulse controller.
//   state_e     : FSM state codes, readable through STATUS[2:0]
//   Addr*       : Avalon-MM word addresses of the register file (0..7)
//   Ctrl*/Stat* : bit positions inside CTRL and STATUS
package step_pulse_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StRun   = 3'd2,
        StRunN  = 3'd3,
        StAuto  = 3'd4
    } state_e;

    localparam logic [3:0] AddrCtrl    = 4'd0;
    localparam logic [3:0] AddrStatus  = 4'd1;
    localparam logic [3:0] AddrPeriod  = 4'd2;
    localparam logic [3:0] AddrPwidth  = 4'd3;
    localparam logic [3:0] AddrNTarget = 4'd4;
    localparam logic [3:0] AddrNDone   = 4'd5;
    localparam logic [3:0] AddrDir     = 4'd6;
    localparam logic [3:0] AddrSetup   = 4'd7;

    localparam int unsigned CtrlStop   = 0;
    localparam int unsigned CtrlStart  = 1;
    localparam int unsigned CtrlStartN = 2;
    localparam int unsigned CtrlInvert = 3;
    localparam int unsigned CtrlAuto   = 4;
    localparam int unsigned CtrlIrqEn  = 5;

    localparam int unsigned StatDone    = 4;
    localparam int unsigned StatAddrErr = 5;

endpackage

// File: rtl/step_period_timer.sv
// Period counter and pulse shaper for the step output.
//   clk, rst     : clock, asynchronous active-high reset
//   run          : the coming cycle is a running cycle (counter advances)
//   period       : raw period request, clamped to P = max(period, 2)
//   pwidth       : raw width request, clamped to W = clamp(pwidth, 1, P-1)
//   pulse_active : pulse level for the coming cycle (feeds the output register)
//   period_end   : the current cycle is the last count (P-1) of a period
//   rise         : the coming cycle is count 0 of a new period
// P and W are sampled only when a new period starts, so mid-run writes take
// effect at the next period boundary.
module step_period_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] pwidth,
    output logic             pulse_active,
    output logic             period_end,
    output logic             rise
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] w_q, w_d;
    logic [CNT_W-1:0] p_new, w_new;
    logic             active_q;
    logic             new_period;

    always_comb begin
        p_new = (period < CNT_W'(2)) ? CNT_W'(2) : period;
        if (pwidth == '0) begin
            w_new = CNT_W'(1);
        end else if (pwidth >= p_new) begin
            w_new = p_new - CNT_W'(1);
        end else begin
            w_new = pwidth;
        end
    end

    assign period_end = active_q && (cnt_q == p_q - CNT_W'(1));
    // A period starts either from standstill or on wrap from P-1.
    assign new_period = run && (!active_q || period_end);

    always_comb begin
        cnt_d = '0;
        p_d   = p_q;
        w_d   = w_q;
        if (new_period) begin
            p_d = p_new;
            w_d = w_new;
        end else if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign pulse_active = run && (cnt_d < w_d);
    assign rise         = new_period;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            p_q      <= '0;
            w_q      <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            w_q      <= w_d;
            active_q <= run;
        end
    end

endmodule

// File: rtl/step_pulse_ctrl.sv
// Avalon-MM controlled step/direction pulse generator for one stepper driver.
//   clk, rst          : 50 MHz clock, asynchronous active-high reset
//   drv_en_SM         : external driver enable, gates pulsing in AUTO
//   period_AUTO       : period used in AUTO
//   dir_AUTO          : direction used in AUTO
//   avs_s0_*          : register bus (4-bit word address, 1-cycle read latency)
//   drv_pulse         : registered step output, XORed with CTRL.invert
//   drv_dir           : registered direction output
//   irq               : STATUS.done & CTRL.irq_en
// Holds the register file, the mode FSM and the N_DONE pulse counter.
module step_pulse_ctrl
    import step_pulse_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned N_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drv_en_SM,
    input  logic [CNT_W-1:0] period_AUTO,
    input  logic             dir_AUTO,
    input  logic [3:0]       avs_s0_address,
    input  logic [31:0]      avs_s0_writedata,
    input  logic             avs_s0_write,
    input  logic             avs_s0_read,
    output logic [31:0]      avs_s0_readdata,
    output logic             drv_pulse,
    output logic             drv_dir,
    output logic             irq
);

    state_e           state_q, state_d;
    state_e           tgt_q, tgt_d;
    logic             stop_q, start_q, start_n_q;
    logic             invert_q, auto_q, irq_en_q;
    logic             done_q, done_d, addr_err_q, addr_err_d;
    logic             dir_q;
    logic [CNT_W-1:0] period_q, pwidth_q, setup_q;
    logic [CNT_W-1:0] setup_cnt_q, setup_cnt_d;
    logic [N_W-1:0]   n_target_q, n_done_q, n_done_d;
    logic             drv_pulse_q, drv_dir_q;
    logic [31:0]      readdata_q, rdata;

    logic             done_set, ndone_clr, setup_done, run_nx, counting_n;
    logic             wr_status, bus_err;
    logic             t_pulse, t_period_end, t_rise;
    logic [CNT_W-1:0] period_src;
    logic             unused_wdata;

    assign unused_wdata = ^avs_s0_writedata;

    // ---------------------------------------------------------------- bus
    assign wr_status = avs_s0_write && (avs_s0_address == AddrStatus);
    assign bus_err   = (avs_s0_write || avs_s0_read) && avs_s0_address[3];

    // Hardware set wins over a same-cycle write-1-to-clear.
    assign done_d     = (done_q && !(wr_status && avs_s0_writedata[StatDone])) || done_set;
    assign addr_err_d = (addr_err_q && !(wr_status && avs_s0_writedata[StatAddrErr])) || bus_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_q     <= 1'b0;
            start_q    <= 1'b0;
            start_n_q  <= 1'b0;
            invert_q   <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            dir_q      <= 1'b0;
            period_q   <= '0;
            pwidth_q   <= '0;
            setup_q    <= '0;
            n_target_q <= '0;
        end else begin
            stop_q     <= 1'b0;
            start_q    <= 1'b0;
            start_n_q  <= 1'b0;
            done_q     <= done_d;
            addr_err_q <= addr_err_d;
            if (avs_s0_write) begin
                case (avs_s0_address)
                    AddrCtrl: begin
                        stop_q    <= avs_s0_writedata[CtrlStop];
                        start_q   <= avs_s0_writedata[CtrlStart];
                        start_n_q <= avs_s0_writedata[CtrlStartN];
                        invert_q  <= avs_s0_writedata[CtrlInvert];
                        auto_q    <= avs_s0_writedata[CtrlAuto];
                        irq_en_q  <= avs_s0_writedata[CtrlIrqEn];
                    end
                    AddrPeriod:  period_q   <= avs_s0_writedata[CNT_W-1:0];
                    AddrPwidth:  pwidth_q   <= avs_s0_writedata[CNT_W-1:0];
                    AddrNTarget: n_target_q <= avs_s0_writedata[N_W-1:0];
                    AddrDir:     dir_q      <= avs_s0_writedata[0];
                    AddrSetup:   setup_q    <= avs_s0_writedata[CNT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (avs_s0_address)
            AddrCtrl: begin
                rdata[CtrlStop]   = stop_q;
                rdata[CtrlStart]  = start_q;
                rdata[CtrlStartN] = start_n_q;
                rdata[CtrlInvert] = invert_q;
                rdata[CtrlAuto]   = auto_q;
                rdata[CtrlIrqEn]  = irq_en_q;
            end
            AddrStatus: begin
                rdata[2:0]         = state_q;
                rdata[StatDone]    = done_q;
                rdata[StatAddrErr] = addr_err_q;
            end
            AddrPeriod:  rdata = 32'(period_q);
            AddrPwidth:  rdata = 32'(pwidth_q);
            AddrNTarget: rdata = 32'(n_target_q);
            AddrNDone:   rdata = 32'(n_done_q);
            AddrDir:     rdata[0] = dir_q;
            AddrSetup:   rdata = 32'(setup_q);
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readdata_q <= '0;
        end else if (avs_s0_read) begin
            readdata_q <= rdata;
        end
    end

    // ---------------------------------------------------------------- FSM
    assign setup_done = (setup_cnt_q >= setup_q);

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        done_set  = 1'b0;
        ndone_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (stop_q) begin
                    state_d = StIdle;
                end else if (auto_q) begin
                    state_d = StAuto;
                end else if (start_q) begin
                    state_d = StSetup;
                    tgt_d   = StRun;
                end else if (start_n_q) begin
                    ndone_clr = 1'b1;
                    if (n_target_q == '0) begin
                        done_set = 1'b1;
                    end else begin
                        state_d = StSetup;
                        tgt_d   = StRunN;
                    end
                end
            end
            StSetup: begin
                if (stop_q) begin
                    state_d = StIdle;
                end else if (setup_done) begin
                    state_d = tgt_q;
                end
            end
            StRun: begin
                if (stop_q) begin
                    state_d = StIdle;
                end
            end
            StRunN: begin
                if (stop_q) begin
                    state_d = StIdle;
                end else if (t_period_end && (n_done_q >= n_target_q)) begin
                    state_d  = StIdle;
                    done_set = 1'b1;
                end
            end
            StAuto: begin
                if (stop_q || !auto_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // run_nx follows the current state, so a stop lets the pulse run for one
    // more cycle (goes inactive on the edge after IDLE is entered). A stop may
    // finish the current period's cycle but never starts a fresh period.
    always_comb begin
        run_nx = 1'b0;
        unique case (state_q)
            StSetup: run_nx = setup_done && !stop_q;
            StRun:   run_nx = !(stop_q && t_period_end);
            StRunN:  run_nx = !(t_period_end && (stop_q || (n_done_q >= n_target_q)));
            StAuto:  run_nx = drv_en_SM && !(stop_q && t_period_end);
            default: run_nx = 1'b0;
        endcase
    end

    assign setup_cnt_d = (state_q == StSetup) ? setup_cnt_q + CNT_W'(1) : '0;
    assign period_src  = (state_q == StAuto) ? period_AUTO : period_q;
    assign counting_n  = (state_q == StRunN) || ((state_q == StSetup) && (tgt_q == StRunN));

    always_comb begin
        n_done_d = n_done_q;
        if (ndone_clr) begin
            n_done_d = '0;
        end else if (t_rise && counting_n && (n_done_q != '1)) begin
            n_done_d = n_done_q + N_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            tgt_q       <= StIdle;
            setup_cnt_q <= '0;
            n_done_q    <= '0;
            drv_pulse_q <= 1'b0;
            drv_dir_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            setup_cnt_q <= setup_cnt_d;
            n_done_q    <= n_done_d;
            drv_pulse_q <= t_pulse ^ invert_q;
            if ((state_q == StIdle) && (state_d == StSetup)) begin
                drv_dir_q <= dir_q;
            end else if (state_d == StAuto) begin
                drv_dir_q <= dir_AUTO;
            end
        end
    end

    step_period_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .run          (run_nx),
        .period       (period_src),
        .pwidth       (pwidth_q),
        .pulse_active (t_pulse),
        .period_end   (t_period_end),
        .rise         (t_rise)
    );

    assign avs_s0_readdata = readdata_q;
    assign drv_pulse       = drv_pulse_q;
    assign drv_dir         = drv_dir_q;
    assign irq             = done_q && irq_en_q;

endmodule

// File: tb/tb_step_pulse_ctrl.sv
// Directed bench for step_pulse_ctrl. Pulse trains are captured one bit per
// clock (bit k = drv_pulse just after the k-th edge following the capture
// start) and compared against hand-derived patterns.
module tb_step_pulse_ctrl;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned N_W   = 16;

    logic             clk;
    logic             rst;
    logic             drv_en_SM;
    logic [CNT_W-1:0] period_AUTO;
    logic             dir_AUTO;
    logic [3:0]       avs_s0_address;
    logic [31:0]      avs_s0_writedata;
    logic             avs_s0_write;
    logic             avs_s0_read;
    logic [31:0]      avs_s0_readdata;
    logic             drv_pulse;
    logic             drv_dir;
    logic             irq;

    int          total;
    int          bad;
    logic [63:0] v;
    logic [31:0] r;

    step_pulse_ctrl #(
        .CNT_W (CNT_W),
        .N_W   (N_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .drv_en_SM        (drv_en_SM),
        .period_AUTO      (period_AUTO),
        .dir_AUTO         (dir_AUTO),
        .avs_s0_address   (avs_s0_address),
        .avs_s0_writedata (avs_s0_writedata),
        .avs_s0_write     (avs_s0_write),
        .avs_s0_read      (avs_s0_read),
        .avs_s0_readdata  (avs_s0_readdata),
        .drv_pulse        (drv_pulse),
        .drv_dir          (drv_dir),
        .irq              (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Write is sampled on the next edge; returns just after that edge.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        avs_s0_address   = a;
        avs_s0_writedata = d;
        avs_s0_write     = 1'b1;
        @(posedge clk);
        #1;
        avs_s0_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        avs_s0_address = a;
        avs_s0_read    = 1'b1;
        @(posedge clk);
        #1;
        avs_s0_read = 1'b0;
        d = avs_s0_readdata;
    endtask

    task automatic cap(input int n, output logic [63:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bits[i] = drv_pulse;
        end
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst              = 1'b1;
        drv_en_SM        = 1'b0;
        period_AUTO      = '0;
        dir_AUTO         = 1'b0;
        avs_s0_address   = '0;
        avs_s0_writedata = '0;
        avs_s0_write     = 1'b0;
        avs_s0_read      = 1'b0;

        // Reset state
        tick(3);
        chk("rst_pulse", 64'(drv_pulse), 64'd0);
        chk("rst_dir", 64'(drv_dir), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_rdata", 64'(avs_s0_readdata), 64'd0);
        rst = 1'b0;
        tick(2);
        rd(4'd1, r);
        chk("rst_status", 64'(r), 64'd0);

        // RUN_N: P=8 W=2 N=3 SETUP=0 -> pulses at t+2, t+10, t+18; IDLE at t+26
        wr(4'd2, 32'd8);
        wr(4'd3, 32'd2);
        wr(4'd4, 32'd3);
        wr(4'd7, 32'd0);
        wr(4'd0, 32'h04);
        cap(24, v);
        chk("runn_train", v, 64'h0006_0606);
        rd(4'd1, r);
        chk("runn_st_a", 64'(r), 64'h03);
        rd(4'd1, r);
        chk("runn_st_b", 64'(r), 64'h03);
        rd(4'd1, r);
        chk("runn_st_done", 64'(r), 64'h10);
        rd(4'd5, r);
        chk("runn_ndone", 64'(r), 64'd3);
        chk("runn_irq_off", 64'(irq), 64'd0);
        cap(10, v);
        chk("runn_no_more", v, 64'd0);

        // RUN then stop on the first pulse edge: exactly 2 high cycles
        wr(4'd1, 32'h10);
        rd(4'd1, r);
        chk("w1c_done", 64'(r), 64'd0);
        wr(4'd2, 32'd10);
        wr(4'd3, 32'd3);
        wr(4'd0, 32'h02);
        tick(1);
        chk("run_setup_low", 64'(drv_pulse), 64'd0);
        wr(4'd0, 32'h01);
        chk("run_first_hi", 64'(drv_pulse), 64'd1);
        cap(12, v);
        chk("stop_trunc", v, 64'h001);
        rd(4'd1, r);
        chk("stop_status", 64'(r), 64'd0);

        // Direction setup: DIR=1, SETUP=5, pulse at t+7, dir at t+1
        wr(4'd6, 32'd1);
        wr(4'd7, 32'd5);
        chk("dir_not_yet", 64'(drv_dir), 64'd0);
        wr(4'd0, 32'h02);
        tick(1);
        chk("dir_loaded", 64'(drv_dir), 64'd1);
        cap(7, v);
        chk("setup_delay", v, 64'h60);
        wr(4'd0, 32'h01);
        tick(3);

        // PERIOD=0, PWIDTH=0 -> 1 high / 1 low
        wr(4'd7, 32'd0);
        wr(4'd2, 32'd0);
        wr(4'd3, 32'd0);
        wr(4'd0, 32'h02);
        cap(8, v);
        chk("clamp_min", v, 64'hAA);
        wr(4'd0, 32'h01);
        tick(3);

        // PERIOD=4, PWIDTH=9 -> 3 high / 1 low
        wr(4'd2, 32'd4);
        wr(4'd3, 32'd9);
        wr(4'd0, 32'h02);
        cap(10, v);
        chk("clamp_max", v, 64'h2EE);
        wr(4'd0, 32'h01);
        tick(3);

        // start_n with N_TARGET=0: done, no pulse, N_DONE cleared
        wr(4'd4, 32'd0);
        wr(4'd0, 32'h04);
        cap(6, v);
        chk("n0_no_pulse", v, 64'd0);
        rd(4'd1, r);
        chk("n0_done", 64'(r), 64'h10);
        rd(4'd5, r);
        chk("n0_ndone", 64'(r), 64'd0);

        // AUTO: period_AUTO=6, W=2, gated by drv_en_SM
        wr(4'd1, 32'h10);
        wr(4'd3, 32'd2);
        period_AUTO = 16'd6;
        dir_AUTO    = 1'b1;
        wr(4'd0, 32'h10);
        cap(5, v);
        chk("auto_gated", v, 64'd0);
        chk("auto_dir", 64'(drv_dir), 64'd1);
        rd(4'd1, r);
        chk("auto_state", 64'(r), 64'h04);
        drv_en_SM = 1'b1;
        cap(8, v);
        chk("auto_train", v, 64'hC3);
        drv_en_SM = 1'b0;
        cap(3, v);
        chk("auto_off", v, 64'd0);
        drv_en_SM = 1'b1;
        cap(3, v);
        chk("auto_restart", v, 64'h3);
        drv_en_SM = 1'b0;
        wr(4'd0, 32'h00);
        tick(3);
        rd(4'd1, r);
        chk("auto_exit", 64'(r), 64'd0);

        // irq: RUN_N P=2 W=1 N=2 with irq_en; done at t+6
        wr(4'd2, 32'd0);
        wr(4'd3, 32'd1);
        wr(4'd4, 32'd2);
        wr(4'd0, 32'h24);
        tick(5);
        chk("irq_before", 64'(irq), 64'd0);
        tick(1);
        chk("irq_set", 64'(irq), 64'd1);
        wr(4'd1, 32'h10);
        chk("irq_clr", 64'(irq), 64'd0);

        // addr_err from an out-of-map write, then W1C
        wr(4'd9, 32'h0);
        rd(4'd1, r);
        chk("addr_err", 64'(r), 64'h20);
        wr(4'd1, 32'h20);
        rd(4'd1, r);
        chk("addr_err_clr", 64'(r), 64'd0);
        rd(4'd0, r);
        chk("ctrl_rb", 64'(r), 64'h20);

        // PERIOD 8 -> 4 written mid-period: current stays 8, next is 4
        wr(4'd2, 32'd8);
        wr(4'd3, 32'd2);
        wr(4'd0, 32'h02);
        tick(3);
        wr(4'd2, 32'd4);
        cap(14, v);
        chk("period_change", v, 64'h2660);
        wr(4'd0, 32'h01);
        tick(3);
        rd(4'd2, r);
        chk("period_rb", 64'(r), 64'd4);

        // invert applies one cycle after the write, also in IDLE
        wr(4'd0, 32'h08);
        chk("inv_lag", 64'(drv_pulse), 64'd0);
        tick(1);
        chk("inv_on", 64'(drv_pulse), 64'd1);
        wr(4'd0, 32'h00);
        tick(1);
        chk("inv_off", 64'(drv_pulse), 64'd0);

        // Asynchronous reset mid-pulse
        wr(4'd2, 32'd10);
        wr(4'd3, 32'd5);
        wr(4'd0, 32'h02);
        tick(3);
        chk("pre_rst_pulse", 64'(drv_pulse), 64'd1);
        chk("pre_rst_dir", 64'(drv_dir), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_pulse", 64'(drv_pulse), 64'd0);
        chk("async_dir", 64'(drv_dir), 64'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        rd(4'd2, r);
        chk("post_rst_period", 64'(r), 64'd0);
        rd(4'd6, r);
        chk("post_rst_dir", 64'(r), 64'd0);
        cap(6, v);
        chk("post_rst_idle", v, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_pulse_ctrl.md
# step_pulse_ctrl

Avalon-MM-controlled step/direction pulse generator for one stepper-motor driver. It is the parametrised successor of the hand/auto pulse block, adding:
- programmable pulse count with true self-termination
- programmable pulse width
- direction-setup delay
- period double-buffering
- a done/IRQ flag

It sits between the Nios register bus and the SM driver pins, with the auto-mode period and direction taken from the ADC-side control path.

## Interface
Parameters:
- CNT_W, 16, width of the period, pulse-width and setup counters
- N_W, 16, width of the pulse-count target and the done counter

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- drv_en_SM  in  1  external driver enable, used in AUTO only
- period_AUTO  in  CNT_W  period in AUTO mode
- dir_AUTO  in  1  direction in AUTO mode
- avs_s0_address  in  4  word address
- avs_s0_writedata  in  32  write data
- avs_s0_write  in  1  write strobe
- avs_s0_read  in  1  read strobe
- avs_s0_readdata  out  32  read data, registered
- drv_pulse  out  1  step output, registered, polarity per CTRL.invert
- drv_dir  out  1  direction output, registered
- irq  out  1  level interrupt, equal to STATUS.done & CTRL.irq_en

## Operation
Register map (unlisted bits read 0):
- 0 CTRL
  - bit0 stop, bit1 start, bit2 start_n: write-1 strobes, self-clear next cycle
  - bit3 invert, bit4 auto, bit5 irq_en: persistent
- 1 STATUS
  - [2:0] state code
  - bit4 done, sticky, write-1-to-clear
  - bit5 addr_err, sticky, write-1-to-clear; set by a write or read to addresses 8–15
- 2 PERIOD, 3 PWIDTH, 4 N_TARGET, 7 SETUP: read/write
- 5 N_DONE: read-only
- 6 DIR: bit0, read/write

FSM states: IDLE=0, SETUP=1, RUN=2, RUN_N=3, AUTO=4.
- **IDLE**
  - Command priority: stop > auto > start > start_n.
  - auto=1 → AUTO.
  - start → SETUP with target RUN.
  - start_n → SETUP with target RUN_N; N_DONE clears to 0.
  - start_n with N_TARGET=0: done sets, state stays IDLE, no pulse.
- **SETUP**
  - drv_dir is loaded from DIR on entry.
  - Waits SETUP clk cycles; SETUP=0 means 0 cycles, so the next state is entered immediately on the following edge.
- **RUN**: pulses continuously until stop.
- **RUN_N**
  - N_DONE increments on each pulse rising edge.
  - After the last cycle of the period in which N_DONE==N_TARGET: → IDLE and done sets.
- **AUTO**
  - Uses period_AUTO and dir_AUTO.
  - While drv_en_SM=0, the period counter is held at 0 and the pulse is inactive.
  - Clearing CTRL.auto → IDLE.
- **stop** in any state → IDLE on the next edge. The pulse goes inactive on the following edge; a pulse in progress is truncated. done is not set.

Period timer:
- Counts 0..P-1; the pulse is active for counts 0..W-1.
- P = max(PERIOD, 2).
- W = clamp(PWIDTH, 1, P-1).
- P and W are latched at count 0 only, so writes made mid-run take effect at the next period boundary.
- Arithmetic is unsigned CNT_W; the counter wraps at P-1 to 0.
- N_DONE saturates at 2^N_W-1.

## Timing
- Reset values:
  - state IDLE
  - all registers 0
  - drv_pulse=0 (invert=0), drv_dir=0, irq=0, avs_s0_readdata=0
- Read latency: 1 cycle; readdata is valid on the edge after avs_s0_read.
- Write-to-state latency: a write of CTRL at edge t registers the strobe; the FSM leaves IDLE at edge t+1.
- First pulse: with SETUP=S, the first active drv_pulse appears at edge t+2+S.
- Stop latency: stop written at edge t, state IDLE at t+1, drv_pulse inactive at t+2.
- invert takes effect on drv_pulse one cycle after the write, including in IDLE.
- Simultaneous W1C write and hardware set of done or addr_err: the set wins.
- An asynchronous reset mid-pulse forces the outputs to their reset values immediately.

## Structure
- Package step_pulse_pkg holds:
  - the state enum with the codes above
  - register address constants 0–7
  - CTRL and STATUS bit indices
- Sub-module step_period_timer contains:
  - the period counter, P/W latch and clamp
  - the pulse shaper
  - its outputs: pulse_active, period_end, rise
- The top level holds the register file, the FSM and N_DONE.

## Test plan
- PERIOD=8, PWIDTH=2, N_TARGET=3, SETUP=0, start_n → exactly 3 pulses, each 2 high / 6 low; done=1 and state IDLE 24 cycles after the first pulse.
- PERIOD=10, PWIDTH=3, start; stop written mid-pulse (during the 2nd high cycle) → pulse truncated to 2 cycles, no further pulses, done=0.
- DIR=1, SETUP=5, start → drv_dir=1 at least 5 cycles before the first pulse rising edge.
- Edge values PERIOD=0, PWIDTH=0 → effective 1 high / 1 low. PERIOD=4, PWIDTH=9 → 3 high / 1 low. N_TARGET=0 with start_n → done set, no pulse.
- AUTO with period_AUTO=6, toggling drv_en_SM → pulses only while the enable is high, counter restarts from 0. irq_en=1 and a completed RUN_N → irq high; W1C of done → irq low.
- Write to address 9 → addr_err=1. PERIOD changed from 8 to 4 mid-period → current period stays 8, next period is 4.
